serial_subtractor: RTL



---
 rtl/serial_subtractor_if.sv | 22 ++
 rtl/serial_subtractor.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/serial_subtractor_if.sv
// Start/busy/done handshake and operand/result bus for serial_subtractor.
// Carries the ovf result only when SERIAL_SUBTRACTOR_OVERFLOW_EN is defined.
interface serial_subtractor_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             borrow;
`ifdef SERIAL_SUBTRACTOR_OVERFLOW_EN
  logic             ovf;

  modport master (output start, a, b, input busy, done, diff, borrow, ovf);
  modport slave  (input start, a, b, output busy, done, diff, borrow, ovf);
`else
  modport master (output start, a, b, input busy, done, diff, borrow);
  modport slave  (input start, a, b, output busy, done, diff, borrow);
`endif
endinterface

// File: rtl/serial_subtractor.sv
// Bit-serial a - b, LSB first, one full-subtractor cell plus a borrow flop.
// Optional signed-overflow output enabled by SERIAL_SUBTRACTOR_OVERFLOW_EN.
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  serial_subtractor_if.slave  bus
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  // Returns {borrow_out, difference} of x - y - bin.
  function automatic logic [1:0] full_sub(input logic x, input logic y, input logic bin);
    logic d;
    logic bout;
    d    = x ^ y ^ bin;
    bout = (~x & y) | (~(x ^ y) & bin);
    return {bout, d};
  endfunction

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] a_sr_q, a_sr_d;
  logic [WIDTH-1:0] b_sr_q, b_sr_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             br_q, br_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             borrow_q, borrow_d;
  logic [1:0]       cell_s;
`ifdef SERIAL_SUBTRACTOR_OVERFLOW_EN
  logic             a_msb_q, a_msb_d;
  logic             b_msb_q, b_msb_d;
  logic             ovf_q, ovf_d;
`endif

  assign cell_s = full_sub(a_sr_q[0], b_sr_q[0], br_q);

  // Next-state, datapath and output-register logic.
  always_comb begin
    state_d  = state_q;
    a_sr_d   = a_sr_q;
    b_sr_d   = b_sr_q;
    res_d    = res_q;
    diff_d   = diff_q;
    cnt_d    = cnt_q;
    br_d     = br_q;
    borrow_d = borrow_q;
`ifdef SERIAL_SUBTRACTOR_OVERFLOW_EN
    a_msb_d  = a_msb_q;
    b_msb_d  = b_msb_q;
    ovf_d    = ovf_q;
`endif
    // Visible flags trail the internal state by one edge so busy covers
    // exactly the WIDTH bit-cycles and done lands on the result update.
    busy_d   = (state_q == ST_SHIFT);
    done_d   = (state_q == ST_DONE);

    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          state_d = ST_SHIFT;
          a_sr_d  = bus.a;
          b_sr_d  = bus.b;
          br_d    = 1'b0;
          cnt_d   = {CW{1'b0}};
`ifdef SERIAL_SUBTRACTOR_OVERFLOW_EN
          a_msb_d = bus.a[WIDTH-1];
          b_msb_d = bus.b[WIDTH-1];
`endif
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SHIFT: begin
        res_d  = {cell_s[0], res_q[WIDTH-1:1]};
        a_sr_d = {1'b0, a_sr_q[WIDTH-1:1]};
        b_sr_d = {1'b0, b_sr_q[WIDTH-1:1]};
        br_d   = cell_s[1];
        cnt_d  = cnt_q + {{(CW-1){1'b0}}, 1'b1};
        if (cnt_q == CNT_LAST) begin
          state_d = ST_DONE;
        end else begin
          state_d = ST_SHIFT;
        end
      end
      ST_DONE: begin
        diff_d   = res_q;
        borrow_d = br_q;
`ifdef SERIAL_SUBTRACTOR_OVERFLOW_EN
        ovf_d    = (a_msb_q != b_msb_q) && (res_q[WIDTH-1] != a_msb_q);
`endif
        if (bus.start) begin
          state_d = ST_SHIFT;
          a_sr_d  = bus.a;
          b_sr_d  = bus.b;
          br_d    = 1'b0;
          cnt_d   = {CW{1'b0}};
`ifdef SERIAL_SUBTRACTOR_OVERFLOW_EN
          a_msb_d = bus.a[WIDTH-1];
          b_msb_d = bus.b[WIDTH-1];
`endif
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      a_sr_q   <= {WIDTH{1'b0}};
      b_sr_q   <= {WIDTH{1'b0}};
      res_q    <= {WIDTH{1'b0}};
      diff_q   <= {WIDTH{1'b0}};
      cnt_q    <= {CW{1'b0}};
      br_q     <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      borrow_q <= 1'b0;
`ifdef SERIAL_SUBTRACTOR_OVERFLOW_EN
      a_msb_q  <= 1'b0;
      b_msb_q  <= 1'b0;
      ovf_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      a_sr_q   <= a_sr_d;
      b_sr_q   <= b_sr_d;
      res_q    <= res_d;
      diff_q   <= diff_d;
      cnt_q    <= cnt_d;
      br_q     <= br_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      borrow_q <= borrow_d;
`ifdef SERIAL_SUBTRACTOR_OVERFLOW_EN
      a_msb_q  <= a_msb_d;
      b_msb_q  <= b_msb_d;
      ovf_q    <= ovf_d;
`endif
    end
  end

  assign bus.busy   = busy_q;
  assign bus.done   = done_q;
  assign bus.diff   = diff_q;
  assign bus.borrow = borrow_q;
`ifdef SERIAL_SUBTRACTOR_OVERFLOW_EN
  assign bus.ovf    = ovf_q;
`endif

endmodule
